pipe_skid_buf: RTL and testbench

Two-entry valid/ready pipeline stage (main register plus skid register) that decouples an upstream producer from a downstream consumer with registered back-pressure. A plain clock-enabled register only lets the writer decide when data moves. This block adds the reader side: the consumer stalls the stage with `out_ready`, and the stall reaches upstream as a registered `in_ready`. It sits between CPU pipeline stages, for example fetch→decode and decode→execute, and wherever a long combinational ready path must be cut.

---
 rtl/pipe_skid_buf.sv | 65 ++++++
 tb/tb_pipe_skid_buf.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry valid/ready stage with registered in_ready.
// Optional stall counter enabled by PIPE_SKID_PERF_EN.
module pipe_skid_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b10, FULL = 2'b11} state_t;
  state_t state;
  logic [WIDTH-1:0] main_q, skid_q;
  logic main_v, skid_v, in_acc, out_acc;
  assign main_v = state[1];
  assign skid_v = state[0];
  // in_ready comes straight from the skid flop, so out_ready never reaches it
  assign in_ready = ~skid_v;
  assign out_valid = main_v;
  assign out_data = main_q;
  assign in_acc = in_valid && in_ready;
  assign out_acc = main_v && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_acc) begin
          state <= BUSY;
          main_q <= in_data;
        end
        BUSY: if (in_acc && out_acc) begin
          main_q <= in_data;
        end else if (in_acc) begin
          state <= FULL;
          skid_q <= in_data;
        end else if (out_acc) begin
          state <= EMPTY;
        end
        FULL: if (out_acc) begin
          state <= BUSY;
          main_q <= skid_q;
        end
        default: state <= EMPTY;
      endcase
    end
`ifdef PIPE_SKID_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (main_v && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_buf.sv
// tb_pipe_skid_buf: directed vector table, hand-written corner sequences and
// random traffic checked against a two-deep FIFO model.
module tb_pipe_skid_buf;
`ifdef PIPE_SKID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic f, iv;
    logic [31:0] d;
    logic ordy, ev, er;
    logic [31:0] ed;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, in_ready3, out_valid3;
  logic [31:0] out_data, out_data3;
  logic [15:0] stall_cnt;
  logic [2:0] stall_cnt3;
  int checks = 0, errors = 0, stall = 0;
  logic [31:0] q[$];
  vec_t vecs[$];
  always #5 clk = ~clk;
  pipe_skid_buf #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );
  pipe_skid_buf #(.WIDTH(32), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .stall_cnt(stall_cnt3)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic step(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
    logic ia, oa;
    flush = f;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    ia = iv && (q.size() < 2);
    oa = (q.size() > 0) && ordy;
    if (q.size() > 0 && !ordy) stall++;
    @(posedge clk);
    if (oa) void'(q.pop_front());
    if (f) q.delete();
    else if (ia) q.push_back(d);
    #1;
  endtask
  task automatic check_model(input string tag);
    int e16, e3;
    e16 = PERF ? (stall > 65535 ? 65535 : stall) : 0;
    e3 = PERF ? (stall > 7 ? 7 : stall) : 0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) chk({tag, "_out_data"}, out_data, q[0]);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(e16));
    chk({tag, "_stall_cnt3"}, 32'(stall_cnt3), 32'(e3));
    chk({tag, "_w3_out_data"}, out_data3, out_data);
  endtask
  initial begin
    vecs.push_back('{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11});
    vecs.push_back('{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22});
    vecs.push_back('{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA1});
    vecs.push_back('{1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 32'hA1});
    vecs.push_back('{1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 32'hA1});
    vecs.push_back('{1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA2});
    vecs.push_back('{1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA3});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b1, 32'hB0});
    for (int k = 1; k <= 8; k++)
      vecs.push_back('{1'b0, 1'b1, 32'hB0 + 32'(k), 1'b1, 1'b1, 1'b1, 32'hB0 + 32'(k)});
    vecs.push_back('{1'b0, 1'b1, 32'hC1, 1'b0, 1'b1, 1'b0, 32'hB8});
    vecs.push_back('{1'b1, 1'b1, 32'hC2, 1'b0, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0});
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      step(vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].er));
      if (vecs[i].ev) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
    end
    step(1'b0, 1'b1, 32'hD1, 1'b0);
    step(1'b0, 1'b1, 32'hD2, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'h1);
    chk("async_out_data", out_data, 32'h0);
    q.delete();
    stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 32'hE1, 1'b1);
    chk("first_accept_out_valid", 32'(out_valid), 32'h1);
    chk("first_accept_out_data", out_data, 32'hE1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'hF1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall5_cnt", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
    chk("stall5_out_data", out_data, 32'hF1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall10_cnt", 32'(stall_cnt), PERF ? 32'd10 : 32'd0);
    chk("stall10_cnt3", 32'(stall_cnt3), PERF ? 32'd7 : 32'd0);
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 31) == 0, 1'($urandom), $urandom, $urandom_range(0, 3) != 0);
      check_model("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
